serial_adder: RTL

- Bit-serial N-bit adder, the addition counterpart of the lab's ripple full-subtractor.
- Adds two parallel operands LSB-first through a single full_adder cell plus a carry flip-flop, one bit per clock.
- Start/done handshake; the result is held stable until the next completion.
- Used as the area-minimal arithmetic unit for the lab's sequential datapath exercises.

---
 rtl/serial_arith_pkg.sv | 12 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder.sv | 114 +++++++++++
 3 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic units: FSM encodings and width limits.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/full_adder.sv
// Single-bit combinational full adder cell, the dual of the lab's full subtractor.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell plus a carry flip-flop, LSB first,
// with a start/done handshake and a result held until the next completion.
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_next;
  logic             load;
  logic [WIDTH-1:0] a_sh, b_sh, res_next;
  logic             carry, s, c;
  logic [CW-1:0]    count;

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("serial_adder: WIDTH out of range");
  end

  full_adder u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (carry),
    .s   (s),
    .cout(c)
  );

  // The partial result only needs WIDTH-1 stored bits; the newest bit comes straight from the cell.
  if (WIDTH == 1) begin : g_res_w1
    assign res_next = s;
  end else begin : g_res_wn
    logic [WIDTH-2:0] res_sh;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               res_sh <= '0;
      else if (state == ST_RUN) res_sh <= res_next[WIDTH-1:1];
    end
    assign res_next = {s, res_sh};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (count == LAST) state_next = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      busy <= (state_next == ST_RUN);
      done <= (state_next == ST_DONE);
      if (load) begin
        a_sh  <= a;
        b_sh  <= b;
        carry <= cin;
        count <= '0;
      end else if (state == ST_RUN) begin
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        carry <= c;
        count <= count + CW'(1);
        if (count == LAST) begin
          sum  <= res_next;
          cout <= c;
        end
      end
    end
  end

endmodule
